// File: rtl/mux_5to1.sv
// Registered 5-input word mux; a non-zero s2 overrides s1 as the select.
// Optional MUX5TO1_SELERR_EN: out-of-range select holds f and flags sel_err.
module mux_5to1 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [2:0]       s1,
  input  logic [2:0]       s2,
  output logic [WIDTH-1:0] f,
  output logic             sel_err
);

  logic [4:0][WIDTH-1:0] a_vec;
  logic [2:0]            sel;
  logic                  sel_oor;
  logic [WIDTH-1:0]      a_sel;

  assign a_vec   = {a4, a3, a2, a1, a0};
  assign sel     = (s2 != 3'b000) ? s2 : s1;
  assign sel_oor = (sel > 3'd4);

  always_comb begin
    a_sel = '0;
    if (!sel_oor) a_sel = a_vec[sel];
  end

`ifdef MUX5TO1_SELERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      f       <= '0;
      sel_err <= 1'b0;
    end else begin
      // out-of-range select keeps the last good word
      if (!sel_oor) f <= a_sel;
      sel_err <= sel_oor;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) f <= '0;
    else     f <= a_sel;
  end

  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_5to1.sv
// Directed bench for mux_5to1; expectations follow MUX5TO1_SELERR_EN if defined.
module tb_mux_5to1;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a0, a1, a2, a3, a4;
  logic [2:0]       s1, s2;
  logic [WIDTH-1:0] f;
  logic             sel_err;

  int n_chk = 0;
  int n_err = 0;

  mux_5to1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .s1(s1), .s2(s2),
    .f(f), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one rising edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 16'h0001;
    sweep_exp[1] = 16'h0010;
    sweep_exp[2] = 16'h0011;
    sweep_exp[3] = 16'h0101;

    rst = 1'b1;
    a0 = 16'h0000; a1 = 16'h0001; a2 = 16'h0010; a3 = 16'h0011; a4 = 16'h0101;
    s1 = 3'd4; s2 = 3'd0;
    step();
    step();
    chk("rst_f", 32'(f), 32'h0000);
    chk("rst_err", 32'(sel_err), 32'd0);

    rst = 1'b0;
    s1 = 3'd4; s2 = 3'd1;
    step();
    chk("ovr_s2_wins", 32'(f), 32'h0001);
    chk("ovr_err", 32'(sel_err), 32'd0);
    s1 = 3'd0; s2 = 3'd1;
    step();
    chk("ovr_s1_0", 32'(f), 32'h0001);
    s1 = 3'd0; s2 = 3'd0;
    step();
    chk("sel_idx0", 32'(f), 32'h0000);
    s1 = 3'd2; s2 = 3'd3;
    step();
    chk("ovr_s2_3", 32'(f), 32'h0011);

    s2 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      s1 = 3'(i + 1);
      step();
      chk($sformatf("sweep_s1_%0d", i + 1), 32'(f), 32'(sweep_exp[i]));
    end

    s1 = 3'd6; s2 = 3'd0;
    step();
`ifdef MUX5TO1_SELERR_EN
    chk("oor_s1_hold", 32'(f), 32'h0101);
    chk("oor_s1_err", 32'(sel_err), 32'd1);
`else
    chk("oor_s1_zero", 32'(f), 32'h0000);
    chk("oor_s1_err", 32'(sel_err), 32'd0);
`endif
    s1 = 3'd2;
    step();
    chk("recover_f", 32'(f), 32'h0010);
    chk("recover_err", 32'(sel_err), 32'd0);

    s1 = 3'd1; s2 = 3'd7;
    step();
`ifdef MUX5TO1_SELERR_EN
    chk("oor_s2_hold", 32'(f), 32'h0010);
    chk("oor_s2_err", 32'(sel_err), 32'd1);
`else
    chk("oor_s2_zero", 32'(f), 32'h0000);
    chk("oor_s2_err", 32'(sel_err), 32'd0);
`endif

    s1 = 3'd3; s2 = 3'd0;
    step();
    chk("pre_rst_f", 32'(f), 32'h0011);
    chk("pre_rst_err", 32'(sel_err), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_f", 32'(f), 32'h0000);
    rst = 1'b0;
    step();
    chk("post_rst_f", 32'(f), 32'h0011);

    s1 = 3'd4;
    step();
    chk("track_base", 32'(f), 32'h0101);
    a4 = 16'hBEEF;
    step();
    chk("track_a4", 32'(f), 32'hBEEF);
    a0 = 16'h1234;
    step();
    chk("track_a0_ign", 32'(f), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux_5to1.md
# mux_5to1

Registered 5-input word multiplexer with two 3-bit select sources. A secondary select `s2` overrides the primary select `s1` whenever `s2` is non-zero. The chosen input is captured into an output register on each clock. The block sits in the datapath wherever one of five same-width operand buses must be steered onto a single registered result bus.

## Interface
Parameters:
- `WIDTH`, default 16: data width of `a0`..`a4` and `f`.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `a0`  input  WIDTH: data input, index 0.
- `a1`  input  WIDTH: data input, index 1.
- `a2`  input  WIDTH: data input, index 2.
- `a3`  input  WIDTH: data input, index 3.
- `a4`  input  WIDTH: data input, index 4.
- `s1`  input  3: primary select index.
- `s2`  input  3: secondary (override) select index.
- `f`  output  WIDTH: registered selected data.
- `sel_err`  output  1: registered flag for an out-of-range effective select.

## Operation
- Effective select: `sel = (s2 != 3'b000) ? s2 : s1`. Any non-zero `s2` has priority over `s1`.
- Consequence: `s2 = 0` always defers to `s1`. Index 0 can only be selected with `s1 = 0` and `s2 = 0`.
- For `sel` 0..4, the next value of `f` is `a[sel]`, with no width change and no arithmetic.
- For `sel` 5..7 (out of range), behaviour is set by the `MUX5TO1_SELERR_EN` configuration below.
- All inputs are sampled on the same edge. There is no handshake, enable or valid signal; the register updates every cycle that is not in reset.

## Timing
- Latency is 1 cycle: inputs present before rising edge N appear on `f` and `sel_err` after edge N.
- Reset (`rst = 1` at a rising edge): `f <= 0` and `sel_err <= 0`. Reset overrides every other input.
- The first edge with `rst = 0` loads the normal selection; there is no extra settling cycle.
- Asserting reset mid-stream clears `f` and `sel_err` on that same edge, regardless of selects.
- Changing a selected data input with selects held changes `f` on the next edge. Changing an unselected input has no effect.
- Outputs are glitch-free. They are driven only from flops, with no combinational path from inputs to outputs.

## Configuration
- Macro: `MUX5TO1_SELERR_EN`.
- When defined:
  - An out-of-range `sel` (5..7) holds `f` at its previous value and sets `sel_err <= 1`.
  - Any in-range `sel` sets `sel_err <= 0`, so the flag is not sticky.
- When not defined:
  - An out-of-range `sel` loads `f <= 0`.
  - `sel_err` is a constant 0; the port remains present.

## Test plan
- Reset: hold `rst = 1` for 2 cycles with `a0..a4 = 16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0101` -> `f = 16'h0000`, `sel_err = 0`.
- Override: `s1 = 3'b100`, `s2 = 3'b001`, one edge -> `f = 16'h0001` (s2 wins over s1 = 4). Then `s1 = 0`, `s2 = 1` -> `f = 16'h0001`. Then `s1 = 0`, `s2 = 0` -> `f = 16'h0000`.
- Primary path: `s2 = 0` and sweep `s1` = 1, 2, 3, 4 -> `f` = `16'h0001`, `16'h0010`, `16'h0011`, `16'h0101`, each exactly one cycle after its select.
- Out-of-range select: from `f = 16'h0101`, apply `s2 = 0`, `s1 = 3'b110`.
  - With `MUX5TO1_SELERR_EN`: `f` stays `16'h0101` and `sel_err = 1`; then `s1 = 2` -> `f = 16'h0010` and `sel_err = 0`.
  - Without the macro: `f = 16'h0000` and `sel_err = 0`.
- Reset mid-stream: with `s1 = 3` producing `f = 16'h0011`, pulse `rst` for 1 cycle -> `f = 16'h0000` on that edge, then `16'h0011` on the next edge.
- Data tracking: hold `s1 = 4`, `s2 = 0` and change `a4` to `16'hBEEF` -> `f = 16'hBEEF` after one edge. Changing `a0` instead leaves `f` unchanged.
